// File: rtl/pipeline_types.sv
// pipeline_types: shared pipeline records plus the branch predictor table entry and counter encodings
package pipeline_types;
  typedef struct packed {
    logic [31:0] pc_dispatch;
    logic        update_en;
    logic        taken_or_not_actual;
    logic [31:0] branch_actual_addr;
    logic        branch_flush;
  } branch_update;
  localparam int BPU_CNT_W = 2;
  localparam logic [BPU_CNT_W-1:0] SNT = 2'd0;
  localparam logic [BPU_CNT_W-1:0] WNT = 2'd1;
  localparam logic [BPU_CNT_W-1:0] WT  = 2'd2;
  localparam logic [BPU_CNT_W-1:0] ST  = 2'd3;
  // Wide enough for pc[31:2]; smaller tables zero-extend their tag into it.
  localparam int BPU_TAG_W = 30;
  typedef struct packed {
    logic                 valid;
    logic [BPU_TAG_W-1:0] tag;
    logic [31:0]          target;
  } bpu_entry_t;
endpackage

// File: rtl/bpu_sat_counter.sv
// bpu_sat_counter: 2-bit saturating counter next-value logic
module bpu_sat_counter
  import pipeline_types::*;
(
  input  logic [BPU_CNT_W-1:0] cnt_in,
  input  logic                 taken,
  output logic [BPU_CNT_W-1:0] cnt_out
);
  always_comb cnt_out = taken ? ((cnt_in == ST) ? ST : cnt_in + BPU_CNT_W'(1))
                              : ((cnt_in == SNT) ? SNT : cnt_in - BPU_CNT_W'(1));
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side BTB + 2-bit BHT with write-first training bypass
module branch_predictor
  import pipeline_types::*;
#(
  parameter int                   ENTRIES  = 64,
  parameter logic [BPU_CNT_W-1:0] CNT_INIT = 2'b10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         fetch_valid,
  input  logic [31:0]  fetch_pc,
  input  branch_update update_info,
  output logic         pred_valid,
  output logic [31:0]  pred_pc,
  output logic         pre_is_branch_taken,
  output logic [31:0]  pre_branch_addr
);
  localparam int IDX_W = $clog2(ENTRIES);
  bpu_entry_t           ent_q [ENTRIES];
  bpu_entry_t           ent_d [ENTRIES];
  logic [BPU_CNT_W-1:0] cnt_q [ENTRIES];
  logic [BPU_CNT_W-1:0] cnt_d [ENTRIES];
  logic [BPU_CNT_W-1:0] cnt_upd;
  logic [IDX_W-1:0]     u_idx, f_idx;
  logic [BPU_TAG_W-1:0] u_tag, f_tag;
  logic                 u_hit, f_hit, f_taken;
  logic                 pred_valid_q, pred_valid_d, pred_taken_q, pred_taken_d;
  logic [31:0]          pred_pc_q, pred_pc_d, pred_addr_q, pred_addr_d;
  logic                 unused_pc_bits;
  assign u_idx = update_info.pc_dispatch[IDX_W+1:2];
  assign u_tag = BPU_TAG_W'(update_info.pc_dispatch[31:IDX_W+2]);
  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = BPU_TAG_W'(fetch_pc[31:IDX_W+2]);
  assign unused_pc_bits = ^update_info.pc_dispatch[1:0];
  bpu_sat_counter u_cnt (
    .cnt_in (cnt_q[u_idx]),
    .taken  (update_info.taken_or_not_actual),
    .cnt_out(cnt_upd)
  );
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    u_hit = ent_q[u_idx].valid && ent_q[u_idx].tag == u_tag;
    if (update_info.update_en && u_hit) begin
      cnt_d[u_idx] = cnt_upd;
      if (update_info.taken_or_not_actual) ent_d[u_idx].target = update_info.branch_actual_addr;
    end else if (update_info.update_en && update_info.taken_or_not_actual) begin
      ent_d[u_idx] = '{valid: 1'b1, tag: u_tag, target: update_info.branch_actual_addr};
      cnt_d[u_idx] = CNT_INIT;
    end
  end
  // Lookup reads the post-update table so a same-cycle train is visible (write-first).
  always_comb begin
    f_hit        = ent_d[f_idx].valid && ent_d[f_idx].tag == f_tag;
    f_taken      = fetch_valid && f_hit && cnt_d[f_idx][1];
    pred_valid_d = update_info.branch_flush ? 1'b0 : stall ? pred_valid_q : fetch_valid;
    pred_pc_d    = update_info.branch_flush ? 32'd0 : stall ? pred_pc_q : fetch_valid ? fetch_pc : 32'd0;
    pred_taken_d = update_info.branch_flush ? 1'b0 : stall ? pred_taken_q : f_taken;
    pred_addr_d  = update_info.branch_flush ? 32'd0 : stall ? pred_addr_q : f_taken ? ent_d[f_idx].target : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= '0;
        cnt_q[i] <= WNT;
      end
      pred_valid_q <= 1'b0;
      pred_pc_q    <= '0;
      pred_taken_q <= 1'b0;
      pred_addr_q  <= '0;
    end else begin
      ent_q        <= ent_d;
      cnt_q        <= cnt_d;
      pred_valid_q <= pred_valid_d;
      pred_pc_q    <= pred_pc_d;
      pred_taken_q <= pred_taken_d;
      pred_addr_q  <= pred_addr_d;
    end
  end
  assign pred_valid          = pred_valid_q;
  assign pred_pc             = pred_pc_q;
  assign pre_is_branch_taken = pred_taken_q;
  assign pre_branch_addr     = pred_addr_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors plus random traffic against a table-level reference model
module tb_branch_predictor;
  import pipeline_types::*;
  localparam logic [31:0] B = 32'h1C000000;
  typedef struct {
    logic        rst, fv;
    logic [31:0] pc;
    logic        stall, en, tk;
    logic [31:0] upc, addr;
    logic        flush;
    logic        ev;
    logic [31:0] epc;
    logic        et;
    logic [31:0] ea;
  } vec_t;
  logic         clk = 1'b0;
  logic         rst, stall, fetch_valid;
  logic [31:0]  fetch_pc;
  branch_update update_info;
  logic         pred_valid, pre_is_branch_taken;
  logic [31:0]  pred_pc, pre_branch_addr;
  int total = 0;
  int bad = 0;
  bit          m_valid [64];
  int unsigned m_tag [64];
  int unsigned m_tgt [64];
  int          m_cnt [64];
  logic        e_v, e_t;
  logic [31:0] e_pc, e_a;
  branch_predictor dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .update_info(update_info), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pre_is_branch_taken(pre_is_branch_taken), .pre_branch_addr(pre_branch_addr)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic f, logic [31:0] p, logic s, logic en, logic tk,
                              logic [31:0] up, logic [31:0] ad, logic fl,
                              logic ev, logic [31:0] epc, logic et, logic [31:0] ea);
    vec_t v;
    v.rst = r; v.fv = f; v.pc = p; v.stall = s; v.en = en; v.tk = tk; v.upc = up; v.addr = ad;
    v.flush = fl; v.ev = ev; v.epc = epc; v.et = et; v.ea = ea;
    return v;
  endfunction
  // Reference: a 64-entry table indexed by (pc/4)%64 with tag pc/256 and an integer counter 0..3.
  task automatic model_step(input vec_t v);
    int i;
    int unsigned tg;
    bit hit;
    if (v.rst) begin
      for (int k = 0; k < 64; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_cnt[k] = 1;
      end
      e_v = 0; e_pc = 0; e_t = 0; e_a = 0;
      return;
    end
    if (v.en) begin
      i = int'((v.upc / 4) % 64);
      tg = v.upc / 256;
      if (m_valid[i] && m_tag[i] == tg) begin
        if (v.tk) begin
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_tgt[i] = v.addr;
        end else m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end else if (v.tk) begin
        m_valid[i] = 1; m_tag[i] = tg; m_tgt[i] = v.addr; m_cnt[i] = 2;
      end
    end
    if (v.flush) begin
      e_v = 0; e_pc = 0; e_t = 0; e_a = 0;
    end else if (!v.stall) begin
      if (v.fv) begin
        i = int'((v.pc / 4) % 64);
        tg = v.pc / 256;
        hit = m_valid[i] && m_tag[i] == tg;
        e_v = 1; e_pc = v.pc; e_t = hit && m_cnt[i] >= 2; e_a = e_t ? m_tgt[i] : 0;
      end else begin
        e_v = 0; e_pc = 0; e_t = 0; e_a = 0;
      end
    end
  endtask
  task automatic apply(input vec_t v, input string nm, input bit use_model);
    logic [65:0] got, want;
    @(negedge clk);
    rst = v.rst; fetch_valid = v.fv; fetch_pc = v.pc; stall = v.stall;
    update_info = '{pc_dispatch: v.upc, update_en: v.en, taken_or_not_actual: v.tk,
                    branch_actual_addr: v.addr, branch_flush: v.flush};
    model_step(v);
    @(posedge clk);
    #1;
    got  = {pred_valid, pred_pc, pre_is_branch_taken, pre_branch_addr};
    want = use_model ? {e_v, e_pc, e_t, e_a} : {v.ev, v.epc, v.et, v.ea};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got v=%0b pc=%h t=%0b a=%h, want v=%0b pc=%h t=%0b a=%h", nm,
               got[65], got[64:33], got[32], got[31:0], want[65], want[64:33], want[32], want[31:0]);
    end
  endtask
  initial begin
    vec_t tbl[$];
    vec_t r;
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,            0,0,0,0));
    tbl.push_back(mk(0,1,B,0,0,0,0,0,0,            1,B,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,B+'h10,B+'h100,0, 0,0,0,0));
    tbl.push_back(mk(0,1,B+'h10,0,0,0,0,0,0,       1,B+'h10,1,B+'h100));
    tbl.push_back(mk(0,0,0,0,1,0,B+'h10,B+'h14,0,  0,0,0,0));
    tbl.push_back(mk(0,1,B+'h10,0,1,0,B+'h10,B+'h14,0, 1,B+'h10,0,0));
    tbl.push_back(mk(0,1,B+'h10,0,1,1,B+'h10,B+'h100,0, 1,B+'h10,0,0));
    tbl.push_back(mk(0,1,B+'h10,0,1,1,B+'h10,B+'h100,0, 1,B+'h10,1,B+'h100));
    tbl.push_back(mk(0,1,B+'h10,0,1,1,B+'h10,B+'h100,0, 1,B+'h10,1,B+'h100));
    tbl.push_back(mk(0,1,B+'h10,0,1,1,B+'h10,B+'h100,0, 1,B+'h10,1,B+'h100));
    tbl.push_back(mk(0,1,B+'h10,0,1,0,B+'h10,0,0,  1,B+'h10,1,B+'h100));
    tbl.push_back(mk(0,1,B+'h110,0,0,0,0,0,0,      1,B+'h110,0,0));
    tbl.push_back(mk(0,1,B+'h10,0,1,1,B+'h110,B+'h300,0, 1,B+'h10,0,0));
    tbl.push_back(mk(0,1,B+'h110,0,0,0,0,0,0,      1,B+'h110,1,B+'h300));
    tbl.push_back(mk(0,1,B+'h20,0,1,1,B+'h20,B+'h200,0, 1,B+'h20,1,B+'h200));
    tbl.push_back(mk(0,1,B+'h30,0,0,1,B+'h30,B+'h330,0, 1,B+'h30,0,0));
    tbl.push_back(mk(0,1,B+'h30,0,0,0,0,0,0,       1,B+'h30,0,0));
    tbl.push_back(mk(0,1,B+'h40,0,1,0,B+'h40,B+'h44,0, 1,B+'h40,0,0));
    tbl.push_back(mk(0,1,B+'h21,0,0,0,0,0,0,       1,B+'h21,1,B+'h200));
    tbl.push_back(mk(0,1,B+'h20,0,0,0,0,0,1,       0,0,0,0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i), 1'b0);
    apply(mk(0,1,B+'h20,0,0,0,0,0,0,               1,B+'h20,1,B+'h200), "stall_pre", 1'b0);
    apply(mk(0,1,B+'h30,1,1,1,B+'h60,B+'h600,0,    1,B+'h20,1,B+'h200), "stall_1", 1'b0);
    apply(mk(0,1,B+'h44,1,0,0,0,0,0,               1,B+'h20,1,B+'h200), "stall_2", 1'b0);
    apply(mk(0,1,B+'h60,1,0,0,0,0,0,               1,B+'h20,1,B+'h200), "stall_3", 1'b0);
    apply(mk(0,1,B+'h60,1,0,0,0,0,1,               0,0,0,0), "stall_flush", 1'b0);
    apply(mk(0,1,B+'h60,1,0,0,0,0,0,               0,0,0,0), "stall_after_flush", 1'b0);
    apply(mk(0,1,B+'h60,0,0,0,0,0,0,               1,B+'h60,1,B+'h600), "update_in_stall", 1'b0);
    apply(mk(0,0,0,0,1,1,B+'h50,B+'h500,0,         0,0,0,0), "train_50", 1'b0);
    apply(mk(1,1,B+'h50,0,0,0,0,0,0,               0,0,0,0), "rst_pulse", 1'b0);
    apply(mk(0,1,B+'h50,0,0,0,0,0,0,               1,B+'h50,0,0), "after_rst_50", 1'b0);
    apply(mk(0,1,B+'h60,0,0,0,0,0,0,               1,B+'h60,0,0), "after_rst_60", 1'b0);
    for (int n = 0; n < 400; n++) begin
      r.rst   = ($urandom_range(0, 149) == 0);
      r.fv    = ($urandom_range(0, 3) != 0);
      r.pc    = B + ($urandom_range(0, 15) << 2) + ($urandom_range(0, 2) << 8) + $urandom_range(0, 3);
      r.stall = ($urandom_range(0, 4) == 0);
      r.en    = ($urandom_range(0, 1) == 1);
      r.tk    = ($urandom_range(0, 2) != 0);
      r.upc   = ($urandom_range(0, 2) == 0) ? r.pc : B + ($urandom_range(0, 15) << 2) + ($urandom_range(0, 2) << 8);
      r.addr  = $urandom;
      r.flush = ($urandom_range(0, 19) == 0);
      r.ev = 0; r.epc = 0; r.et = 0; r.ea = 0;
      apply(r, $sformatf("rand%0d", n), 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
